pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch/decode/execute sequencer that drives the program counter's control pins (ldPC, PCinc, add) and the instruction-fetch handshake.
- Issues one instruction at a time to the datapath.
- Handles JMP, BRZ and HLT locally; all other opcodes go to the execute unit.
- Sits between the program counter, instruction memory and the ALU/register-file control.

Parameters:
PC_LAT, 2, cycles from a PC control action until the PC address output is valid; the sequencer waits this long before fetching
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before entering FAULT
OP_JMP, 4'hC, opcode for unconditional jump
OP_BRZ, 4'hD, opcode for jump-if-zero_flag
OP_HLT, 4'hF, opcode for halt

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin execution (sampled in IDLE) / resume (sampled in HALT)
mem_ack  input  1  instruction memory ack; mem_rdata is valid in the same cycle
mem_rdata  input  16  fetched instruction
zero_flag  input  1  ALU zero flag, sampled in DECODE
exec_done  input  1  execute unit finished the current instruction
ldPC  output  1  PC load control
PCinc  output  1  PC increment control
add  output  12  PC load address
mem_req  output  1  instruction fetch request
ir  output  16  instruction register
ir_valid  output  1  ir holds an instruction under execution
exec_start  output  1  one-cycle pulse to start the execute unit
halted  output  1  in HALT
fault  output  1  in FAULT (fetch timeout)

Behaviour:
- PC control encoding {ldPC,PCinc}:
  - 00 = CLEAR (PC to 000)
  - 10 = LOAD add
  - 01 = INC
  - 11 = HOLD
  - Every state drives HOLD unless stated otherwise.
- Reset (reset_n=0, async) forces:
  - state=IDLE; ldPC=0, PCinc=0 (CLEAR); add=0, mem_req=0, ir=0, ir_valid=0, exec_start=0, halted=0, fault=0.
  - Reset mid-operation aborts immediately, with the same values.
- All outputs are registered.
- States and transitions:
  - IDLE: drives CLEAR. start=1 -> SETTLE.
  - SETTLE: HOLD; counts PC_LAT cycles, then -> FETCH.
  - FETCH:
    - mem_req=1, held until mem_ack.
    - On mem_ack: ir<=mem_rdata, mem_req drops next cycle, -> DECODE.
    - If MEM_TIMEOUT cycles elapse with no ack -> FAULT.
  - DECODE (1 cycle), by ir[15:12]:
    - OP_HLT -> HALT.
    - OP_JMP -> JUMP.
    - OP_BRZ -> JUMP if zero_flag=1, else -> INC.
    - Any other opcode -> EXEC.
  - EXEC:
    - exec_start=1 for the first cycle only.
    - ir_valid=1 throughout.
    - exec_done=1 -> INC. exec_done in the entry cycle is accepted.
  - INC: {ldPC,PCinc}=01 for exactly one cycle -> SETTLE.
  - JUMP: {ldPC,PCinc}=10 with add=ir[11:0] for exactly one cycle -> SETTLE. add holds its last value otherwise.
  - HALT: halted=1. start=1 -> INC (resume at the next address).
  - FAULT: fault=1, HOLD. Exits only via reset_n.
- Inputs are ignored outside the states listed:
  - start outside IDLE/HALT.
  - mem_ack outside FETCH.
  - exec_done outside EXEC.
- Boundary conditions:
  - Jump to self (target = current PC) is legal and loops.
  - PC wrap FFF->000 on INC is the PC's behaviour; the sequencer does not detect it.
  - mem_ack in the cycle the timeout expires: ack wins.
- Latency (ALU instruction, zero-wait memory): INC, then PC_LAT SETTLE cycles, then FETCH, DECODE, EXEC. That is 5 cycles of overhead plus execute time.

Test Plan:
- Reset, then start=1 for one cycle -> CLEAR held in IDLE; mem_req rises exactly 2 cycles after leaving IDLE; PC address = 000.
- Fetch 16'h1234 (ack 1 cycle), exec_done 3 cycles later -> exec_start pulses once, ir=1234, ir_valid high in EXEC, one INC cycle, next fetch at address 001.
- Fetch 16'hC0A5 -> one LOAD cycle with add=0A5, next fetch address 0A5. Fetch 16'hD010 with zero_flag=0 -> INC; with zero_flag=1 -> LOAD add=010.
- Fetch 16'hF000 -> halted=1 and HOLD persists for 20 cycles; start=1 -> INC, next fetch at previous address+1.
- Hold mem_ack=0 for 16 cycles in FETCH -> fault=1, mem_req=0, HOLD; start ignored; reset_n low -> all outputs return to reset values asynchronously.
- Assert reset_n=0 mid-EXEC -> state IDLE, CLEAR driven, exec_start/ir_valid=0 before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer: drives the PC control pins and the instruction-fetch
// handshake, resolves JMP/BRZ/HLT locally and hands every other opcode to the execute unit.
module pc_sequencer #(
    parameter int         PC_LAT      = 2,
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [3:0] OP_JMP      = 4'hC,
    parameter logic [3:0] OP_BRZ      = 4'hD,
    parameter logic [3:0] OP_HLT      = 4'hF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        zero_flag,
    input  logic        exec_done,
    output logic        ldPC,
    output logic        PCinc,
    output logic [11:0] add,
    output logic        mem_req,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        exec_start,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [3:0] {
        IDLE, SETTLE, FETCH, DECODE, EXEC, INC, JUMP, HALT, FAULT
    } state_t;

    localparam logic [1:0] PC_CLEAR = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_LOAD  = 2'b10;
    localparam logic [1:0] PC_HOLD  = 2'b11;

    localparam int CNT_MAX = (PC_LAT > MEM_TIMEOUT) ? PC_LAT : MEM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state, next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pcctl_d;
    logic             mem_req_d, ir_valid_d, exec_start_d, halted_d, fault_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    // Shared dwell counter: restarts on every state change, used by SETTLE and FETCH only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                              cnt <= '0;
        else if (next != state)                    cnt <= '0;
        else if (state == SETTLE || state == FETCH) cnt <= cnt + CNT_W'(1);
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   if (start) next = SETTLE;
            SETTLE: if (cnt == CNT_W'(PC_LAT - 1)) next = FETCH;
            FETCH: begin
                // An ack arriving in the last allowed cycle still completes the fetch.
                if (mem_ack)                                next = DECODE;
                else if (cnt == CNT_W'(MEM_TIMEOUT - 1))    next = FAULT;
            end
            DECODE: begin
                if (ir[15:12] == OP_HLT)      next = HALT;
                else if (ir[15:12] == OP_JMP) next = JUMP;
                else if (ir[15:12] == OP_BRZ) next = zero_flag ? JUMP : INC;
                else                          next = EXEC;
            end
            EXEC:       if (exec_done) next = INC;
            INC, JUMP:  next = SETTLE;
            HALT:       if (start) next = INC;
            FAULT:      next = FAULT;
            default:    next = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        pcctl_d = PC_HOLD;
        case (next)
            IDLE:    pcctl_d = PC_CLEAR;
            INC:     pcctl_d = PC_INC;
            JUMP:    pcctl_d = PC_LOAD;
            default: pcctl_d = PC_HOLD;
        endcase
        mem_req_d    = (next == FETCH);
        ir_valid_d   = (next == EXEC);
        exec_start_d = (next == EXEC) && (state != EXEC);
        halted_d     = (next == HALT);
        fault_d      = (next == FAULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            {ldPC, PCinc} <= PC_CLEAR;
            add           <= '0;
            mem_req       <= 1'b0;
            ir            <= '0;
            ir_valid      <= 1'b0;
            exec_start    <= 1'b0;
            halted        <= 1'b0;
            fault         <= 1'b0;
        end else begin
            {ldPC, PCinc} <= pcctl_d;
            mem_req       <= mem_req_d;
            ir_valid      <= ir_valid_d;
            exec_start    <= exec_start_d;
            halted        <= halted_d;
            fault         <= fault_d;
            if (state == FETCH && mem_ack) ir  <= mem_rdata;
            if (next == JUMP)              add <= ir[11:0];
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a PC model driven by the control pins plus an instruction-level
// model of the expected fetch address, with directed and randomized instruction streams.
module tb_pc_sequencer;

    localparam int PC_LAT      = 2;
    localparam int MEM_TIMEOUT = 16;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BRZ = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int CLR = 0, INCC = 1, LOAD = 2, HOLD = 3;

    logic        clock = 1'b0;
    logic        reset_n, start, mem_ack, zero_flag, exec_done;
    logic [15:0] mem_rdata;
    logic        ldPC, PCinc, mem_req, ir_valid, exec_start, halted, fault;
    logic [11:0] add;
    logic [15:0] ir;
    logic [1:0]  ctrl;
    logic [11:0] pc_model;
    logic [11:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    pc_sequencer #(
        .PC_LAT(PC_LAT), .MEM_TIMEOUT(MEM_TIMEOUT),
        .OP_JMP(OP_JMP), .OP_BRZ(OP_BRZ), .OP_HLT(OP_HLT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .zero_flag(zero_flag), .exec_done(exec_done),
        .ldPC(ldPC), .PCinc(PCinc), .add(add), .mem_req(mem_req), .ir(ir),
        .ir_valid(ir_valid), .exec_start(exec_start), .halted(halted), .fault(fault)
    );

    always #5 clock = ~clock;
    assign ctrl = {ldPC, PCinc};

    // Program counter as seen by the sequencer: reacts to the control pins at each edge.
    always @(posedge clock) begin
        case (ctrl)
            2'b00:   pc_model <= '0;
            2'b10:   pc_model <= add;
            2'b01:   pc_model <= pc_model + 12'd1;
            default: pc_model <= pc_model;
        endcase
    end

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!mem_req && n < 64) begin
            step();
            n++;
        end
        if (!mem_req) begin
            chk("req_wait_expired", 32'(mem_req), 1);
            finish_sim();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"},       32'(ctrl), CLR);
        chk({tag, "_add"},        32'(add), 0);
        chk({tag, "_mem_req"},    32'(mem_req), 0);
        chk({tag, "_ir"},         32'(ir), 0);
        chk({tag, "_ir_valid"},   32'(ir_valid), 0);
        chk({tag, "_exec_start"}, 32'(exec_start), 0);
        chk({tag, "_halted"},     32'(halted), 0);
        chk({tag, "_fault"},      32'(fault), 0);
    endtask

    // Hold reset for two edges, release it, idle a little, then start execution at PC 000.
    task automatic boot();
        int n;
        step();
        step();
        chk_reset("rst");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'($urandom);
            exec_done = 1'($urandom);
            step();
            chk("idle_clear", 32'(ctrl), CLR);
            chk("idle_req", 32'(mem_req), 0);
        end
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        chk("pc_cleared", 32'(pc_model), 0);
        exp_pc = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_req(n);
        chk("start_to_req", n, PC_LAT);
    endtask

    // Entered in the first FETCH cycle; returns in the first FETCH cycle of the next instruction.
    task automatic run_instr(input logic [15:0] instr, input int ack_delay, input bit zf,
                             input int exec_lat, input int halt_cycles, input bit abort_exec);
        logic [3:0] op;
        int         n;
        op = instr[15:12];
        chk("fetch_addr", 32'(pc_model), 32'(exp_pc));
        for (int i = 0; i < ack_delay; i++) begin
            mem_rdata = 16'($urandom);
            step();
            chk("req_held", 32'(mem_req), 1);
            chk("no_fault", 32'(fault), 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = instr;
        zero_flag = zf;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        chk("req_drop", 32'(mem_req), 0);
        chk("ir_load", 32'(ir), 32'(instr));
        step();
        if (op == OP_HLT) begin
            chk("halted", 32'(halted), 1);
            chk("halt_hold", 32'(ctrl), HOLD);
            for (int i = 0; i < halt_cycles; i++) begin
                mem_ack   = 1'($urandom);
                exec_done = 1'($urandom);
                step();
                chk("halt_stay", 32'(halted), 1);
                chk("halt_ctrl", 32'(ctrl), HOLD);
            end
            mem_ack   = 1'b0;
            exec_done = 1'b0;
            start = 1'b1;
            step();
            start = 1'b0;
            chk("resume_inc", 32'(ctrl), INCC);
            chk("halt_clear", 32'(halted), 0);
            exp_pc = exp_pc + 12'd1;
        end else if (op == OP_JMP || (op == OP_BRZ && zf)) begin
            chk("load_ctrl", 32'(ctrl), LOAD);
            chk("load_addr", 32'(add), 32'(instr[11:0]));
            chk("jump_no_exec", 32'(exec_start), 0);
            exp_pc = instr[11:0];
        end else if (op == OP_BRZ) begin
            chk("brz_inc", 32'(ctrl), INCC);
            chk("brz_no_exec", 32'(exec_start), 0);
            exp_pc = exp_pc + 12'd1;
        end else begin
            chk("exec_start", 32'(exec_start), 1);
            chk("exec_ir_valid", 32'(ir_valid), 1);
            chk("exec_ir", 32'(ir), 32'(instr));
            if (abort_exec) begin
                #2 reset_n = 1'b0;
                #1;
                chk_reset("async_exec");
                return;
            end
            for (int i = 0; i <= exec_lat; i++) begin
                exec_done = (i == exec_lat);
                start     = 1'($urandom);
                mem_ack   = 1'($urandom);
                step();
                if (i < exec_lat) begin
                    chk("exec_single_pulse", 32'(exec_start), 0);
                    chk("exec_ir_valid_hold", 32'(ir_valid), 1);
                end
            end
            exec_done = 1'b0;
            start     = 1'b0;
            mem_ack   = 1'b0;
            chk("exec_inc", 32'(ctrl), INCC);
            chk("exec_ir_valid_off", 32'(ir_valid), 0);
            exp_pc = exp_pc + 12'd1;
        end
        wait_req(n);
        chk("settle_to_req", n, PC_LAT + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        finish_sim();
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        zero_flag = 1'b0; exec_done = 1'b0;
        boot();

        run_instr(16'h1234, 1, 1'b0, 3, 0, 1'b0);
        run_instr(16'hC0A5, 0, 1'b0, 0, 0, 1'b0);
        run_instr(16'hD010, 0, 1'b0, 0, 0, 1'b0);
        run_instr(16'hD010, 0, 1'b1, 0, 0, 1'b0);
        run_instr(16'h5A5A, 0, 1'b0, 0, 0, 1'b0);
        run_instr(16'hF000, 0, 1'b0, 0, 20, 1'b0);
        run_instr({OP_JMP, exp_pc}, 0, 1'b0, 0, 0, 1'b0);
        run_instr({OP_JMP, exp_pc}, 2, 1'b0, 0, 0, 1'b0);
        run_instr(16'hCFFF, 0, 1'b0, 0, 0, 1'b0);
        run_instr(16'h2345, 0, 1'b0, 1, 0, 1'b0);
        run_instr(16'hE001, MEM_TIMEOUT - 1, 1'b0, 2, 0, 1'b0);

        repeat (40) begin
            int         r;
            logic [3:0] op;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                op = 4'($urandom_range(0, 12));
                if (op == 4'd12) op = 4'hE;
            end else if (r == 6) op = OP_JMP;
            else if (r <= 8)     op = OP_BRZ;
            else                 op = OP_HLT;
            run_instr({op, 12'($urandom)}, $urandom_range(0, 3), 1'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            mem_rdata = 16'($urandom);
            step();
            chk("timeout_req_held", 32'(mem_req), 1);
            chk("timeout_no_fault", 32'(fault), 0);
        end
        step();
        chk("fault_set", 32'(fault), 1);
        chk("fault_req_low", 32'(mem_req), 0);
        chk("fault_hold", 32'(ctrl), HOLD);
        for (int i = 0; i < 5; i++) begin
            start   = 1'b1;
            mem_ack = 1'($urandom);
            step();
            chk("fault_stays", 32'(fault), 1);
            chk("fault_ctrl", 32'(ctrl), HOLD);
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_reset("async_fault");

        boot();
        run_instr(16'h3C3C, 0, 1'b0, 2, 0, 1'b1);
        boot();
        run_instr(16'h7001, 1, 1'b0, 0, 0, 1'b0);

        finish_sim();
    end

endmodule
